seg_decoder_monitor: RTL

- Receive end of the 7-segment display bus driven by the team's counter/display blocks.
- Samples the 8-bit segment bus (dp + a..g), requires the pattern to hold steady, and decodes it back to a 4-bit digit.
- Flags illegal patterns and out-of-sequence digits, and keeps a saturating error count.
- Used as a self-checking scoreboard in benches and as an on-board loopback checker.

---
 rtl/seg_decoder_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_decoder_monitor.sv
// rtl/seg_decoder_monitor.sv - 7-segment bus receiver: sync, debounce, decode, sequence/error check
`timescale 1ns/1ps
module seg_decoder_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_DIGIT     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  output logic [3:0] digit,
  output logic       dp_out,
  output logic       valid,
  output logic       new_digit,
  output logic       invalid_err,
  output logic       seq_err,
  output logic [7:0] err_count
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] MAX_D      = 4'(MAX_DIGIT);

  typedef enum logic {NOREF, TRACK} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_sync1, r_sync2, r_last;
  logic [3:0] r_stable_cnt;
  logic [3:0] r_digit;
  logic       r_dp, r_valid, r_new, r_inv, r_seq;
  logic [7:0] r_err;

  logic       w_accept, w_blank, w_same, w_legal;
  logic [3:0] w_val, w_expect;
  logic [3:0] w_digit_nxt;
  logic       w_dp_nxt, w_valid_nxt, w_new_nxt, w_inv_nxt, w_seq_nxt;

  // r_stable_cnt is the number of consecutive samples equal to the current r_sync2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= 8'h00;
      r_sync2      <= 8'h00;
      r_stable_cnt <= 4'd0;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2)
        r_stable_cnt <= 4'd1;
      else if (r_stable_cnt != STABLE_MAX)
        r_stable_cnt <= r_stable_cnt + 4'd1;
    end
  end

  assign w_accept = (r_stable_cnt == STABLE_MAX) && (r_sync2 != r_last);
  assign w_blank  = (r_sync2[6:0] == 7'h00);
  assign w_same   = (r_sync2[6:0] == r_last[6:0]);
  assign w_expect = (r_digit == MAX_D) ? 4'd0 : r_digit + 4'd1;

  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'd0;
    case (r_sync2[6:0])
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_legal = 1'b0;
    endcase
    if (w_val > MAX_D)
      w_legal = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= NOREF;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && !w_same) begin
      if (w_blank || !w_legal)
        w_state_nxt = NOREF;
      else
        w_state_nxt = TRACK;
    end
  end

  // A dp-only change updates dp_out and nothing else
  always_comb begin
    w_digit_nxt = r_digit;
    w_dp_nxt    = r_dp;
    w_valid_nxt = r_valid;
    w_new_nxt   = 1'b0;
    w_inv_nxt   = 1'b0;
    w_seq_nxt   = 1'b0;
    if (w_accept) begin
      w_dp_nxt = r_sync2[7];
      if (!w_same) begin
        if (w_blank) begin
          w_valid_nxt = 1'b0;
        end else if (!w_legal) begin
          w_valid_nxt = 1'b0;
          w_inv_nxt   = 1'b1;
        end else begin
          w_digit_nxt = w_val;
          w_valid_nxt = 1'b1;
          w_new_nxt   = 1'b1;
          if (r_state == TRACK && w_val != 4'd0 && w_val != w_expect)
            w_seq_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 8'h00;
      r_digit <= 4'd0;
      r_dp    <= 1'b0;
      r_valid <= 1'b0;
      r_new   <= 1'b0;
      r_inv   <= 1'b0;
      r_seq   <= 1'b0;
      r_err   <= 8'h00;
    end else begin
      if (w_accept)
        r_last <= r_sync2;
      r_digit <= w_digit_nxt;
      r_dp    <= w_dp_nxt;
      r_valid <= w_valid_nxt;
      r_new   <= w_new_nxt;
      r_inv   <= w_inv_nxt;
      r_seq   <= w_seq_nxt;
      if ((w_inv_nxt || w_seq_nxt) && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
    end
  end

  assign digit       = r_digit;
  assign dp_out      = r_dp;
  assign valid       = r_valid;
  assign new_digit   = r_new;
  assign invalid_err = r_inv;
  assign seq_err     = r_seq;
  assign err_count   = r_err;

endmodule
